// File: rtl/cva6_pma_order_guard.sv
// Request guard between the CVA6 data port and the NoC adapter.
// Registers requests, tags PMA class, orders non-idempotent accesses.
module cva6_pma_order_guard #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MAX_OUTST = 7,
  parameter int unsigned NR_NI     = 2,
  parameter logic [NR_NI*ADDR_W-1:0] NI_BASE = '0,
  parameter logic [NR_NI*ADDR_W-1:0] NI_LEN  = '0,
  parameter int unsigned NR_CA     = 1,
  parameter logic [NR_CA*ADDR_W-1:0] CA_BASE = 64'h8000_0000,
  parameter logic [NR_CA*ADDR_W-1:0] CA_LEN  = 64'h4000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [ID_W-1:0]   req_id_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_we_o,
  output logic [ID_W-1:0]   out_id_o,
  output logic              out_cached_o,
  output logic              out_nonidem_o,
  input  logic              rsp_valid_i,
  output logic [7:0]        outst_o,
  output logic              err_o
);

  localparam logic [7:0] MaxOutst = 8'(MAX_OUTST);

  typedef enum logic [1:0] {
    PASS,
    DRAIN,
    WAIT_NI
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [ID_W-1:0]   id;
    logic              cached;
    logic              nonidem;
  } entry_t;

  state_e     state;
  state_e     stateNext;
  entry_t     held;
  logic       full;
  logic [7:0] outstCnt;
  logic       errQ;
  logic       hitNi;
  logic       hitCa;
  logic       permit;
  logic       issue;
  logic       outFire;
  logic       accept;
  logic       rspOk;

  // One extra bit keeps base+len from wrapping at the top of memory.
  function automatic logic inRegion(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] len
  );
    logic [ADDR_W:0] top;
    top = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < top);
  endfunction

  // Classify the incoming address against all region rules.
  always_comb begin
    hitNi = 1'b0;
    hitCa = 1'b0;
    for (int i = 0; i < NR_NI; i++) begin
      hitNi = hitNi | inRegion(req_addr_i,
                               NI_BASE[i*ADDR_W +: ADDR_W],
                               NI_LEN[i*ADDR_W +: ADDR_W]);
    end
    for (int i = 0; i < NR_CA; i++) begin
      hitCa = hitCa | inRegion(req_addr_i,
                               CA_BASE[i*ADDR_W +: ADDR_W],
                               CA_LEN[i*ADDR_W +: ADDR_W]);
    end
  end

  // Ordering FSM: decides whether the held entry may go out.
  always_comb begin
    permit    = 1'b0;
    stateNext = state;
    unique case (state)
      PASS: begin
        if (!held.nonidem) begin
          permit = 1'b1;
        end else if (outstCnt == '0) begin
          permit = 1'b1;
          if (full && out_ready_i) stateNext = WAIT_NI;
        end else if (full) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (outstCnt == '0) stateNext = PASS;
      end
      WAIT_NI: begin
        if (outstCnt == '0) stateNext = PASS;
      end
      default: stateNext = PASS;
    endcase
  end

  assign issue   = full & (outstCnt < MaxOutst) & permit;
  assign outFire = issue & out_ready_i;
  assign accept  = req_valid_i & req_ready_o;
  assign rspOk   = rsp_valid_i & (outstCnt != '0);

  assign req_ready_o   = ~full | outFire;
  assign out_valid_o   = issue;
  assign out_addr_o    = held.addr;
  assign out_we_o      = held.we;
  assign out_id_o      = held.id;
  assign out_cached_o  = held.cached;
  assign out_nonidem_o = held.nonidem;
  assign outst_o       = outstCnt;
  assign err_o         = errQ;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= PASS;
    else         state <= stateNext;
  end

  // Single-entry holding register; refills in the cycle it drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full <= 1'b0;
      held <= '0;
    end else if (accept) begin
      full         <= 1'b1;
      held.addr    <= req_addr_i;
      held.we      <= req_we_i;
      held.id      <= req_id_i;
      held.cached  <= hitCa;
      held.nonidem <= hitNi;
    end else if (outFire) begin
      full <= 1'b0;
    end
  end

  // Outstanding counter and sticky underflow error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstCnt <= '0;
      errQ     <= 1'b0;
    end else begin
      if (outFire && !rspOk)      outstCnt <= outstCnt + 8'd1;
      else if (!outFire && rspOk) outstCnt <= outstCnt - 8'd1;
      if (rsp_valid_i && outstCnt == '0) errQ <= 1'b1;
    end
  end

endmodule
